// File: rtl/loop_filter_gearshift.sv
// loop_filter_gearshift: ADPLL PI loop filter with valid-qualified error, acquire/track gain sets and lock-driven gear shifting
// Ports:
//   gen_clk_i, reset_i         clock, synchronous active-high reset
//   valid_i, error_i           qualified signed phase-error sample
//   kp_acq_i, ki_acq_i         unsigned PI gains used while acquiring
//   kp_trk_i, ki_trk_i         unsigned PI gains used while tracking
//   freeze_i                   hold integrator, P path stays live
//   force_acq_i                force ACQUIRE and clear the lock counter
//   dco_cc_o, valid_o          saturated signed DCO code and its one-cycle update strobe
//   locked_o, sat_o            TRACK indicator, clamp indicator for the last update
module loop_filter_gearshift #(
    parameter int ERROR_WIDTH   = 8,
    parameter int KP_WIDTH      = 6,
    parameter int KI_WIDTH      = 6,
    parameter int FRAC_BITS     = 4,
    parameter int ACC_WIDTH     = 20,
    parameter int DCO_CC_WIDTH  = 8,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 8,
    parameter int LOCK_COUNT    = 16
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_i,
    input  logic                           valid_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_i,
    input  logic        [KP_WIDTH-1:0]     kp_acq_i,
    input  logic        [KI_WIDTH-1:0]     ki_acq_i,
    input  logic        [KP_WIDTH-1:0]     kp_trk_i,
    input  logic        [KI_WIDTH-1:0]     ki_trk_i,
    input  logic                           freeze_i,
    input  logic                           force_acq_i,
    output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                           valid_o,
    output logic                           locked_o,
    output logic                           sat_o
);
    localparam int PW = ERROR_WIDTH + KP_WIDTH + 1;
    localparam int QW = ERROR_WIDTH + KI_WIDTH + 1;
    localparam int IW = ACC_WIDTH + 1;
    localparam int SW = (PW > ACC_WIDTH ? PW : ACC_WIDTH) + 1;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [ERROR_WIDTH:0] LT = (ERROR_WIDTH+1)'(LOCK_THRESH);
    localparam logic [ERROR_WIDTH:0] UT = (ERROR_WIDTH+1)'(UNLOCK_THRESH);
    localparam logic [CW-1:0] LC = CW'(LOCK_COUNT);

    typedef enum logic {ACQUIRE, TRACK} state_t;

    state_t                         state, state_n;
    logic        [CW-1:0]           cnt, cnt_n;
    logic                           v_r;
    logic signed [ERROR_WIDTH-1:0]  e_r;
    logic signed [ACC_WIDTH-1:0]    integ, i_next;
    logic        [KP_WIDTH-1:0]     kp;
    logic        [KI_WIDTH-1:0]     ki;
    logic signed [PW-1:0]           p;
    logic signed [QW-1:0]           q;
    logic signed [IW-1:0]           i_sum;
    logic                           i_ovf, o_ovf;
    logic signed [SW-1:0]           sum;
    logic signed [DCO_CC_WIDTH-1:0] cc;
    logic signed [ERROR_WIDTH:0]    ex;
    logic        [ERROR_WIDTH:0]    mag;

    assign locked_o = state == TRACK;

    // Datapath: gains come from the pre-edge state so a gear change affects the next sample only
    always_comb begin
        kp     = state == TRACK ? kp_trk_i : kp_acq_i;
        ki     = state == TRACK ? ki_trk_i : ki_acq_i;
        p      = PW'(e_r) * PW'($signed({1'b0, kp}));
        q      = QW'(e_r) * QW'($signed({1'b0, ki}));
        i_sum  = IW'(integ) + IW'(q);
        // One guard bit suffices: the product is narrower than the accumulator
        i_ovf  = !freeze_i && (i_sum[IW-1] != i_sum[IW-2]);
        i_next = freeze_i ? integ :
                 i_ovf ? {i_sum[IW-1], {(ACC_WIDTH-1){~i_sum[IW-1]}}} : i_sum[ACC_WIDTH-1:0];
        sum    = (SW'(p) + SW'(i_next)) >>> FRAC_BITS;
        o_ovf  = sum != SW'($signed(sum[DCO_CC_WIDTH-1:0]));
        cc     = o_ovf ? {sum[SW-1], {(DCO_CC_WIDTH-1){~sum[SW-1]}}} : sum[DCO_CC_WIDTH-1:0];
        ex     = {e_r[ERROR_WIDTH-1], e_r};
        mag    = ex[ERROR_WIDTH] ? -ex : ex;
    end

    // Lock FSM next state; force_acq_i wins over any sample-driven transition
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (v_r) begin
            if (state == ACQUIRE) begin
                cnt_n = mag <= LT ? cnt + 1'b1 : '0;
                if (cnt_n == LC) begin
                    state_n = TRACK;
                    cnt_n   = '0;
                end
            end else if (mag > UT) begin
                state_n = ACQUIRE;
                cnt_n   = '0;
            end
        end
        if (force_acq_i) begin
            state_n = ACQUIRE;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            state <= ACQUIRE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            v_r      <= 1'b0;
            e_r      <= '0;
            integ    <= '0;
            dco_cc_o <= '0;
            valid_o  <= 1'b0;
            sat_o    <= 1'b0;
        end else begin
            v_r     <= valid_i;
            valid_o <= v_r;
            if (valid_i)
                e_r <= error_i;
            if (v_r) begin
                integ    <= i_next;
                dco_cc_o <= cc;
                sat_o    <= i_ovf | o_ovf;
            end
        end
    end
endmodule

// File: tb/tb_loop_filter_gearshift.sv
// tb_loop_filter_gearshift: directed-vector bench for loop_filter_gearshift
module tb_loop_filter_gearshift;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              valid = 1'b0;
    logic signed [7:0] error = '0;
    logic        [5:0] kp_acq = '0, ki_acq = '0, kp_trk = '0, ki_trk = '0;
    logic              freeze = 1'b0;
    logic              force_acq = 1'b0;
    logic signed [7:0] dco_cc;
    logic              valid_o, locked, sat;
    int                errors = 0;
    int                checks = 0;
    int                pulses = 0;

    loop_filter_gearshift dut (
        .gen_clk_i(clk), .reset_i(reset), .valid_i(valid), .error_i(error),
        .kp_acq_i(kp_acq), .ki_acq_i(ki_acq), .kp_trk_i(kp_trk), .ki_trk_i(ki_trk),
        .freeze_i(freeze), .force_acq_i(force_acq),
        .dco_cc_o(dco_cc), .valid_o(valid_o), .locked_o(locked), .sat_o(sat)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step;
        reset = 1'b0;
    endtask

    // One isolated sample; returns just after the edge that presents its output
    task automatic send(input int e);
        valid = 1'b1;
        error = 8'(e);
        step;
        valid = 1'b0;
        step;
    endtask

    initial begin
        step;
        step;
        reset = 1'b0;
        chk("rst_dco", dco_cc, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sat", sat, 0);
        chk("rst_integ", dut.integ, 0);

        // Back-to-back samples, latency 2
        kp_acq = 6'd4; ki_acq = 6'd2; kp_trk = 6'd4; ki_trk = 6'd2;
        valid = 1'b1; error = 8'sd8;
        step; chk("b2b_lat", valid_o, 0);
        step; chk("b2b_v1", valid_o, 1); chk("b2b_d1", dco_cc, 3); chk("b2b_i1", dut.integ, 16);
        step; valid = 1'b0;
        chk("b2b_d2", dco_cc, 4); chk("b2b_i2", dut.integ, 32);
        step; chk("b2b_d3", dco_cc, 5); chk("b2b_i3", dut.integ, 48); chk("b2b_sat", sat, 0);
        step; chk("b2b_end", valid_o, 0); chk("b2b_hold", dco_cc, 5);

        // Floor shift and output clamp
        do_reset;
        kp_acq = 6'd1; ki_acq = 6'd0;
        send(-1); chk("floor_d", dco_cc, -1); chk("floor_sat", sat, 0);
        kp_acq = 6'd63;
        send(-128); chk("oclamp_d", dco_cc, -128); chk("oclamp_sat", sat, 1);

        // Integrator anti-windup
        do_reset;
        kp_acq = 6'd63; ki_acq = 6'd63;
        repeat (100) send(127);
        chk("iclamp_i", dut.integ, 524287); chk("iclamp_d", dco_cc, 127); chk("iclamp_sat", sat, 1);
        send(-8); chk("unwind_i1", dut.integ, 523783); chk("unwind_d1", dco_cc, 127);
        send(-8); chk("unwind_i2", dut.integ, 523279);

        // Lock counting, restart, gear shift, unlock boundary
        do_reset;
        kp_acq = 6'd16; ki_acq = 6'd0; kp_trk = 6'd32; ki_trk = 6'd0;
        repeat (9) send(1);
        send(3); chk("restart_d", dco_cc, 3); chk("restart_lk", locked, 0);
        send(-2); chk("thresh_d", dco_cc, -2);
        repeat (14) send(1); chk("lk15", locked, 0);
        send(1); chk("lk16", locked, 1); chk("lk16_d", dco_cc, 1);
        send(1); chk("trk_d", dco_cc, 2);
        send(8); chk("trk8_lk", locked, 1); chk("trk8_d", dco_cc, 16);
        send(9); chk("unlock_lk", locked, 0); chk("unlock_d", dco_cc, 18);
        send(1); chk("reacq_d", dco_cc, 1);

        // force_acq_i out of TRACK
        repeat (15) send(1); chk("relock", locked, 1);
        force_acq = 1'b1; step; force_acq = 1'b0;
        chk("force_lk", locked, 0);
        send(1); chk("force_d", dco_cc, 1);
        repeat (14) send(1); chk("force_cnt", locked, 0);

        // Gapped valid pattern 1,0,0,1
        do_reset;
        pulses = 0;
        kp_acq = 6'd16; ki_acq = 6'd0;
        valid = 1'b1; error = 8'sd4;
        step; valid = 1'b0; pulses += int'(valid_o); chk("gap_e1", valid_o, 0);
        step; pulses += int'(valid_o); chk("gap_e2", dco_cc, 4);
        step; pulses += int'(valid_o); chk("gap_e3", valid_o, 0);
        valid = 1'b1; error = 8'sd8;
        step; valid = 1'b0; pulses += int'(valid_o); chk("gap_hold", dco_cc, 4);
        step; pulses += int'(valid_o); chk("gap_e5", dco_cc, 8);
        step; pulses += int'(valid_o);
        chk("gap_pulses", pulses, 2);

        // Freeze keeps the integrator, P follows error
        do_reset;
        kp_acq = 6'd16; ki_acq = 6'd16;
        send(2); chk("frz_i0", dut.integ, 32); chk("frz_d0", dco_cc, 4);
        freeze = 1'b1;
        send(2); chk("frz_i1", dut.integ, 32); chk("frz_d1", dco_cc, 4);
        send(5); chk("frz_i2", dut.integ, 32); chk("frz_d2", dco_cc, 7);
        freeze = 1'b0;
        send(5); chk("thaw_i", dut.integ, 112); chk("thaw_d", dco_cc, 12);

        // Reset between sample and output
        valid = 1'b1; error = 8'sd5;
        step;
        valid = 1'b0; reset = 1'b1;
        step;
        reset = 1'b0;
        chk("mid_valid", valid_o, 0); chk("mid_dco", dco_cc, 0); chk("mid_sat", sat, 0);
        chk("mid_integ", dut.integ, 0);
        step; chk("mid_valid2", valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/loop_filter_gearshift.md
Name: loop_filter_gearshift

Overview:
- Next-generation ADPLL PI loop filter with a valid-qualified error input, two runtime gain sets and automatic gear shifting.
- Uses the acquire gains until a lock detector sees sustained small phase error, then switches to the track gains; falls back to acquire on large error.
- Integrator has anti-windup clamping; output saturates rather than wrapping.
- Sits between the phase detector/TDC and the DCO control-code input.

Parameters:
ERROR_WIDTH, 8, signed phase-error width
KP_WIDTH, 6, unsigned proportional gain width
KI_WIDTH, 6, unsigned integral gain width
FRAC_BITS, 4, fractional bits removed from the PI sum by arithmetic right shift
ACC_WIDTH, 20, signed integrator width (>= ERROR_WIDTH+KI_WIDTH+1)
DCO_CC_WIDTH, 8, signed output control-code width
LOCK_THRESH, 2, |error| <= this counts as an in-lock sample
UNLOCK_THRESH, 8, |error| > this while tracking drops lock
LOCK_COUNT, 16, consecutive in-lock samples required to enter TRACK (>= 1)

Ports:
gen_clk_i  in  1  single clock domain
reset_i  in  1  synchronous, active-high reset
valid_i  in  1  error_i qualifier; one sample per high cycle
error_i  in  ERROR_WIDTH  signed phase error
kp_acq_i  in  KP_WIDTH  unsigned Kp, ACQUIRE gear
ki_acq_i  in  KI_WIDTH  unsigned Ki, ACQUIRE gear
kp_trk_i  in  KP_WIDTH  unsigned Kp, TRACK gear
ki_trk_i  in  KI_WIDTH  unsigned Ki, TRACK gear
freeze_i  in  1  hold integrator (P path still active)
force_acq_i  in  1  force ACQUIRE state, clear lock counter
dco_cc_o  out  DCO_CC_WIDTH  signed saturated control code
valid_o  out  1  one-cycle strobe, dco_cc_o updated
locked_o  out  1  high in TRACK state
sat_o  out  1  high when the last output or integrator update clipped

Behaviour:
Reset:
- Synchronous reset: on a gen_clk_i edge with reset_i high, all registers clear.
- Reset values: dco_cc_o=0, valid_o=0, locked_o=0, sat_o=0, integrator=0, lock counter=0, state=ACQUIRE.
- reset_i mid-stream discards any sample in the pipeline; valid_o is not asserted for it.

Pipeline (latency 2 edges):
- Stage 1 (edge k): when valid_i=1, register error_i into e_r and set v_r. v_r=0 otherwise.
- Stage 2 (edge k+1, v_r=1): update integrator, lock FSM, dco_cc_o, sat_o. Assert valid_o for exactly one cycle.
- When v_r=0: dco_cc_o and all state hold, valid_o=0.
- Back-to-back valid_i is supported at full rate.

Arithmetic (stage 2):
- Gains are taken from the current registered state, i.e. the state before this sample's transition.
- p = e_r * kp, with kp zero-extended and the product signed.
- i_next = clamp(integ + e_r*ki) to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- If freeze_i=1: i_next = integ.
- sum = (p + i_next) >>> FRAC_BITS, floor rounding. Intermediate is wide enough never to overflow.
- dco_cc_o = clamp(sum) to DCO_CC_WIDTH signed range.
- sat_o = 1 if either clamp was active on this update, else 0. Updated only on valid samples.

Lock FSM (advances only on stage-2 valid samples):
- ACQUIRE:
  - |e_r| <= LOCK_THRESH: cnt += 1. When cnt reaches LOCK_COUNT, go to TRACK and clear cnt.
  - Otherwise: cnt = 0.
- TRACK:
  - |e_r| > UNLOCK_THRESH: go to ACQUIRE, cnt = 0.
  - Otherwise: stay in TRACK.
- |e_r| for the most-negative error is computed at ERROR_WIDTH+1 bits, so no overflow.
- force_acq_i=1 in any cycle: state=ACQUIRE, cnt=0. It overrides the transition of a simultaneous valid sample; that sample still produces an output using the pre-edge gains.
- locked_o is registered and changes on the same edge as the state.
- Gear change is bumpless: the integrator is not modified on a transition.

Test Plan:
- Reset, then kp_acq=4, ki_acq=2, error_i=+8 with valid_i every cycle -> first valid_o two edges after the first sample; dco_cc_o = 3, then 4, 5 (integrator 16, 32, 48); sat_o=0.
- kp=1, ki=0, error_i=-1 -> dco_cc_o=-1 (floor shift); error_i=-128, kp=63 -> dco_cc_o=-128, sat_o=1.
- error_i=+127, kp=ki=63 held for 100 samples -> integrator clamps at 524287; dco_cc_o=127, sat_o=1. Then error_i=-8: dco_cc_o drops below 127 on the first negative sample's output only if the P term dominates; integrator decreases by exactly 504 per sample (no windup beyond the clamp).
- error_i=+1 for 16 valid samples -> locked_o rises on the 16th sample's stage-2 edge and trk gains apply from the 17th. A sample of +3 at sample 10 restarts the count. error_i=+9 in TRACK -> locked_o=0 on that sample's edge.
- valid_i gapped pattern 1,0,0,1 -> exactly two valid_o pulses; dco_cc_o holds between them. freeze_i=1 -> integrator constant while P term tracks error.
- reset_i asserted between a valid_i sample and its output -> no valid_o; all outputs 0 the next cycle. force_acq_i in TRACK -> locked_o=0 next edge.
